round_robin_encoder: RTL and testbench
======================================

ROUND_ROBIN_ENCODER -- requirements
Module: round_robin_encoder

Interface
REQ-001 Parameter N, default 8, number of request lines; the block SHALL support 2 <= N <= 64.
REQ-002 Parameter RR, default 1; the block SHALL use rotating priority when RR=1 and fixed LSB-first priority when RR=0.
REQ-003 Derived parameter W = clog2(N), default 3, index width; the block SHALL compute W internally and not expose it for override.
REQ-004 Clock  input  1  the block SHALL use this as its sole clock, rising edge.
REQ-005 Reset  input  1  the block SHALL treat this as an asynchronous, active-high reset.
REQ-006 Enable  input  1  the block SHALL capture new requests only while Enable=1.
REQ-007 Req  input  N  the block SHALL treat Req as the request vector, where bit i means requester i is asking.
REQ-008 Ready  input  1  the block SHALL treat Ready as the downstream accept signal.
REQ-009 Valid  output  1  the block SHALL drive Valid=1 when Index/OneHot hold an unaccepted grant.
REQ-010 Index  output  W  the block SHALL drive Index as the binary-encoded granted requester.
REQ-011 OneHot  output  N  the block SHALL drive OneHot as the decoded grant, 1 << Index when Valid=1, otherwise all zeros.

Function
REQ-012 The block SHALL keep an internal priority pointer Ptr of width W, valid range 0..N-1.
REQ-013 A load condition SHALL exist when Enable=1, Req != 0, and (Valid=0 or Ready=1).
REQ-014 On load, the block SHALL select the first set Req bit found scanning circularly from Ptr upward (RR=1), or from bit 0 upward (RR=0).
REQ-015 On load, the block SHALL register Index, OneHot and Valid=1 at the next rising edge, giving 1-cycle latency from Req to Valid.
REQ-016 On load with RR=1, the block SHALL set Ptr to Index+1, wrapping from N-1 to 0 (including non-power-of-two N).
REQ-017 With RR=0, the block SHALL hold Ptr at 0.
REQ-018 Hold: when Valid=1 and Ready=0, the block SHALL keep Index, OneHot and Ptr stable regardless of Req and Enable.
REQ-019 Drain: when Valid=1, Ready=1 and no load condition exists, the block SHALL clear Valid and OneHot at the next edge, keep Index at its last value, and keep Ptr unchanged.
REQ-020 Back-to-back: when Valid=1, Ready=1 and a load condition exists, the block SHALL accept the current grant and register the new one in the same edge with no bubble.
REQ-021 When Enable=0 and Valid=0, the block SHALL keep outputs at Valid=0 and OneHot=0 and keep Ptr unchanged.
REQ-022 The block SHALL ignore Req bits at or above N; a single requester SHALL be granted repeatedly on every load.
REQ-023 Outputs SHALL be registered only, with no combinational path from Req, Enable or Ready to any output.

Reset
REQ-024 While Reset=1, the block SHALL immediately force Valid=0, Index=0, OneHot=0 and Ptr=0, without waiting for a clock edge.
REQ-025 Reset asserted mid-hold SHALL discard the pending grant; after release, the first load SHALL scan from bit 0.
REQ-026 On the first rising edge after Reset falls, the block SHALL apply normal REQ-013..REQ-021 behaviour.

Verification (N=8, RR=1 unless noted)
REQ-027 The bench SHALL check: Reset=1 with Req=8'hFF -> Valid=0, Index=3'd0, OneHot=8'h00, with no clock edge needed.
REQ-028 The bench SHALL check: Enable=1, Ready=1, Req=8'b00100100 held -> successive grants Index=2 (OneHot=8'b00000100), then 5 (8'b00100000), then 2 (wrap), each 1 cycle apart with Valid continuously 1.
REQ-029 The bench SHALL check: after a grant at Index=5, Ready=0 for 3 cycles while Req changes to 8'h01 -> Index=5 and Valid=1 held; Ready=1 -> next edge Index=0.
REQ-030 The bench SHALL check: Enable=0, Req=8'h80 for 4 cycles -> Valid=0 throughout; Enable=1 -> next edge Index=7, Valid=1.
REQ-031 The bench SHALL check: Valid=1, Ready=1, Req=8'h00 -> next edge Valid=0 and OneHot=8'h00.
REQ-032 The bench SHALL check: with RR=0, Req=8'b10000010 held with Ready=1 -> Index=1 on every grant.

Source files
------------

// File: rtl/round_robin_encoder.sv
// Request encoder with rotating (RR=1) or fixed LSB-first (RR=0) priority.
// Grant is registered and held until accepted by ready_i; outputs are registered only.
module round_robin_encoder #(
  parameter int unsigned N  = 8,
  parameter int unsigned RR = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [N-1:0]           req_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [$clog2(N)-1:0]   index_o,
  output logic [N-1:0]           onehot_o
);

  localparam int unsigned W  = $clog2(N);
  localparam int unsigned WP = W + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   index_q, index_d;
  logic [N-1:0]   onehot_q, onehot_d;
  logic [W-1:0]   ptr_q, ptr_d;

  logic [W-1:0]   scan_base;
  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] req_rot;
  logic [W-1:0]   pick_off;
  logic           pick_found;
  logic [WP-1:0]  pick_sum;
  logic [W-1:0]   pick_idx;
  logic [W-1:0]   pick_ptr;
  logic           load;

  // Rotate requests so the scan start sits at bit 0, then find the first set bit.
  always_comb begin
    scan_base  = (RR != 0) ? ptr_q : '0;
    req_dbl    = {req_i, req_i};
    req_rot    = req_dbl >> scan_base;
    pick_off   = '0;
    pick_found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!pick_found && req_rot[k]) begin
        pick_found = 1'b1;
        pick_off   = W'(k);
      end
    end
    pick_sum = WP'(scan_base) + WP'(pick_off);
    if (pick_sum >= WP'(N)) begin
      pick_sum = pick_sum - WP'(N);
    end
    pick_idx = pick_sum[W-1:0];
    pick_ptr = (pick_idx == W'(N - 1)) ? '0 : pick_idx + W'(1);
  end

  assign load = enable_i && pick_found && ((state_q == ST_IDLE) || ready_i);

  // Next-state: load a new grant, hold an unaccepted one, or drain when accepted.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    onehot_d = onehot_q;
    ptr_d    = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d  = ST_GRANT;
          index_d  = pick_idx;
          onehot_d = N'(1) << pick_idx;
          if (RR != 0) ptr_d = pick_ptr;
        end
      end
      ST_GRANT: begin
        if (ready_i) begin
          if (load) begin
            index_d  = pick_idx;
            onehot_d = N'(1) << pick_idx;
            if (RR != 0) ptr_d = pick_ptr;
          end else begin
            state_d  = ST_IDLE;
            onehot_d = '0;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      index_q  <= '0;
      onehot_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
    end
  end

  assign valid_o  = (state_q == ST_GRANT);
  assign index_o  = index_q;
  assign onehot_o = onehot_q;

endmodule

// File: tb/tb_round_robin_encoder.sv
// Directed bench: rotating-priority instance (N=8, RR=1) and fixed-priority instance (N=8, RR=0).
module tb_round_robin_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, ready;
  logic [7:0] req;
  logic       valid;
  logic [2:0] index;
  logic [7:0] onehot;

  logic       en_fx, ready_fx;
  logic [7:0] req_fx;
  logic       valid_fx;
  logic [2:0] index_fx;
  logic [7:0] onehot_fx;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  round_robin_encoder #(.N(8), .RR(1)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .req_i(req), .ready_i(ready),
    .valid_o(valid), .index_o(index), .onehot_o(onehot)
  );

  round_robin_encoder #(.N(8), .RR(0)) dut_fx (
    .clk_i(clk), .rst_i(rst), .enable_i(en_fx), .req_i(req_fx), .ready_i(ready_fx),
    .valid_o(valid_fx), .index_o(index_fx), .onehot_o(onehot_fx)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; ready = 1'b1; req = 8'hFF;
    en_fx = 1'b0; ready_fx = 1'b1; req_fx = 8'h00;
    #2;
    total++; if (valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid); else passed++;
    total++; if (index !== 3'd0) $display("FAIL reset_index got=%0d exp=0", index); else passed++;
    total++; if (onehot !== 8'h00) $display("FAIL reset_onehot got=%h exp=00", onehot); else passed++;
    step();
    step();
    total++; if (valid !== 1'b0 || onehot !== 8'h00)
      $display("FAIL reset_held got v=%b oh=%h exp v=0 oh=00", valid, onehot); else passed++;
    rst = 1'b0; en = 1'b0; req = 8'h00;
  endtask

  task automatic test_rotate();
    logic [2:0] exp_idx [3];
    logic [7:0] exp_oh  [3];
    exp_idx[0] = 3'd2; exp_oh[0] = 8'b0000_0100;
    exp_idx[1] = 3'd5; exp_oh[1] = 8'b0010_0000;
    exp_idx[2] = 3'd2; exp_oh[2] = 8'b0000_0100;
    en = 1'b1; ready = 1'b1; req = 8'b0010_0100;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (valid !== 1'b1 || index !== exp_idx[i] || onehot !== exp_oh[i])
        $display("FAIL rotate_%0d got v=%b idx=%0d oh=%b exp v=1 idx=%0d oh=%b",
                 i, valid, index, onehot, exp_idx[i], exp_oh[i]); else passed++;
    end
  endtask

  task automatic test_hold();
    step();
    total++; if (valid !== 1'b1 || index !== 3'd5)
      $display("FAIL hold_setup got v=%b idx=%0d exp v=1 idx=5", valid, index); else passed++;
    ready = 1'b0; req = 8'h01;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) en = 1'b0;
      step();
      total++; if (valid !== 1'b1 || index !== 3'd5 || onehot !== 8'h20)
        $display("FAIL hold_%0d got v=%b idx=%0d oh=%h exp v=1 idx=5 oh=20",
                 i, valid, index, onehot); else passed++;
    end
    en = 1'b1; ready = 1'b1;
    step();
    total++; if (valid !== 1'b1 || index !== 3'd0 || onehot !== 8'h01)
      $display("FAIL hold_release got v=%b idx=%0d oh=%h exp v=1 idx=0 oh=01",
               valid, index, onehot); else passed++;
  endtask

  task automatic test_enable();
    en = 1'b0; req = 8'h80; ready = 1'b1;
    step();
    total++; if (valid !== 1'b0) $display("FAIL enable_drain got v=%b exp v=0", valid); else passed++;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (valid !== 1'b0 || onehot !== 8'h00)
        $display("FAIL enable_off_%0d got v=%b oh=%h exp v=0 oh=00", i, valid, onehot); else passed++;
    end
    en = 1'b1;
    step();
    total++; if (valid !== 1'b1 || index !== 3'd7 || onehot !== 8'h80)
      $display("FAIL enable_on got v=%b idx=%0d oh=%h exp v=1 idx=7 oh=80",
               valid, index, onehot); else passed++;
  endtask

  task automatic test_drain();
    req = 8'h00; ready = 1'b1;
    step();
    total++; if (valid !== 1'b0 || onehot !== 8'h00 || index !== 3'd7)
      $display("FAIL drain got v=%b idx=%0d oh=%h exp v=0 idx=7 oh=00",
               valid, index, onehot); else passed++;
  endtask

  task automatic test_single();
    req = 8'h08;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (valid !== 1'b1 || index !== 3'd3 || onehot !== 8'h08)
        $display("FAIL single_%0d got v=%b idx=%0d oh=%h exp v=1 idx=3 oh=08",
                 i, valid, index, onehot); else passed++;
    end
  endtask

  task automatic test_reset_mid_hold();
    req = 8'h40;
    step();
    total++; if (valid !== 1'b1 || index !== 3'd6)
      $display("FAIL mid_setup got v=%b idx=%0d exp v=1 idx=6", valid, index); else passed++;
    ready = 1'b0;
    step();
    rst = 1'b1;
    #1;
    total++; if (valid !== 1'b0 || index !== 3'd0 || onehot !== 8'h00)
      $display("FAIL mid_reset got v=%b idx=%0d oh=%h exp v=0 idx=0 oh=00",
               valid, index, onehot); else passed++;
    step();
    rst = 1'b0; req = 8'hFF; ready = 1'b1; en = 1'b1;
    step();
    total++; if (valid !== 1'b1 || index !== 3'd0 || onehot !== 8'h01)
      $display("FAIL post_reset_first got v=%b idx=%0d oh=%h exp v=1 idx=0 oh=01",
               valid, index, onehot); else passed++;
    step();
    total++; if (valid !== 1'b1 || index !== 3'd1)
      $display("FAIL post_reset_second got v=%b idx=%0d exp v=1 idx=1", valid, index); else passed++;
    en = 1'b0; req = 8'h00;
  endtask

  task automatic test_fixed();
    en_fx = 1'b1; ready_fx = 1'b1; req_fx = 8'b1000_0010;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (valid_fx !== 1'b1 || index_fx !== 3'd1 || onehot_fx !== 8'h02)
        $display("FAIL fixed_%0d got v=%b idx=%0d oh=%h exp v=1 idx=1 oh=02",
                 i, valid_fx, index_fx, onehot_fx); else passed++;
    end
    req_fx = 8'h00;
    step();
    total++; if (valid_fx !== 1'b0)
      $display("FAIL fixed_drain got v=%b exp v=0", valid_fx); else passed++;
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_hold();
    test_enable();
    test_drain();
    test_single();
    test_reset_mid_hold();
    test_fixed();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
